cgra_cfg_loader: RTL and testbench

Sequencing controller for the CGRA array. It streams a configuration bitstream from a local config RAM into the CGRA configuration port (`io_cfg_en/addr/data`) at one word per cycle. After the stream it inserts a fixed settle gap, then holds the array enables (`io_en_0..7`) high for a programmed number of compute cycles. It replaces the open-loop bench sequencing with a synthesizable start/busy/done engine driven by the host.

---
 rtl/cgra_ctrl_pkg.sv | 42 ++++
 rtl/cgra_cfg_loader_if.sv | 36 +++
 rtl/cgra_cfg_fetch.sv | 94 +++++++++
 rtl/cgra_cfg_loader.sv | 115 +++++++++++
 tb/tb_cgra_cfg_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_ctrl_pkg.sv
// Shared constants, state encoding and config-word field layout for the CGRA
// configuration loader.
package cgra_ctrl_pkg;

  localparam int CFG_LENGTH = 64;
  localparam int CFGW       = 52;
  localparam int CGRA_AW    = 18;
  localparam int DW         = 32;
  localparam int RUNW       = 16;
  localparam int NEN        = 8;

  localparam int AW   = $clog2(CFG_LENGTH);
  localparam int LENW = AW + 1;

  // Config word layout: [51:32] address field, [31:0] data field.
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = DW - 1;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_MSB = ADDR_LSB + CGRA_AW - 1;
  localparam int HI_LSB   = ADDR_MSB + 1;
  localparam int HI_MSB   = CFGW - 1;

  // Idle gap after the last config write, plus the RAM + output register
  // latency that the final words still need after the last read issues.
  localparam int DRAIN_CYCLES = 2;
  localparam int FETCH_LAT    = 2;
  localparam int DRAIN_TOTAL  = FETCH_LAT + DRAIN_CYCLES;
  localparam int DCW          = $clog2(DRAIN_TOTAL);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } cgra_state_e;

  function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
    return (len > LENW'(CFG_LENGTH)) ? LENW'(CFG_LENGTH) : len;
  endfunction

endpackage

// File: rtl/cgra_cfg_loader_if.sv
// Host, config-RAM and CGRA-port signal bundle for cgra_cfg_loader.
interface cgra_cfg_loader_if;
  import cgra_ctrl_pkg::*;

  // start: one-cycle request, taken only while busy is low; abort wins over
  // start. done: one-cycle pulse at the end of a run. mem_rd_data is valid
  // exactly one cycle after mem_rd_en; there is no back-pressure anywhere.
  logic                  start;
  logic                  abort;
  logic [LENW-1:0]       cfg_len;
  logic [RUNW-1:0]       run_cycles;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [CFGW-1:0]       mem_rd_data;
  logic                  io_cfg_en;
  logic [CGRA_AW-1:0]    io_cfg_addr;
  logic [DW-1:0]         io_cfg_data;
  logic [NEN-1:0]        io_en;
  logic                  busy;
  logic                  done;
  logic                  err;
  cgra_state_e           dbg_state;

  modport master (
    output start, abort, cfg_len, run_cycles, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, io_cfg_en, io_cfg_addr, io_cfg_data,
    input  io_en, busy, done, err, dbg_state
  );

  modport slave (
    input  start, abort, cfg_len, run_cycles, mem_rd_data,
    output mem_rd_en, mem_rd_addr, io_cfg_en, io_cfg_addr, io_cfg_data,
    output io_en, busy, done, err, dbg_state
  );

endinterface

// File: rtl/cgra_cfg_fetch.sv
// Config RAM read sequencer: address counter, RAM-latency valid tracking and
// the registered CGRA config write port. Optional CGRA_CFG_ADDR_CHECK_EN.
module cgra_cfg_fetch
  import cgra_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_start_i,
  input  logic               flush_i,
  input  logic               clr_err_i,
  input  logic [LENW-1:0]    len_i,
  output logic               mem_rd_en_o,
  output logic [AW-1:0]      mem_rd_addr_o,
  input  logic [CFGW-1:0]    mem_rd_data_i,
  output logic               last_issue_o,
  output logic               cfg_en_o,
  output logic [CGRA_AW-1:0] cfg_addr_o,
  output logic [DW-1:0]      cfg_data_o,
  output logic               err_o
);

  logic               rd_en_q;
  logic [AW-1:0]      rd_addr_q;
  logic               pend_q;
  logic               cfg_en_q;
  logic [CGRA_AW-1:0] cfg_addr_q;
  logic [DW-1:0]      cfg_data_q;
  logic               addr_ok;

  // len_i is already latched by the time the first read is outstanding.
  assign last_issue_o = rd_en_q && ((LENW'(rd_addr_q) + LENW'(1)) == len_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pend_q     <= 1'b0;
      cfg_en_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else if (flush_i) begin
      rd_en_q  <= 1'b0;
      pend_q   <= 1'b0;
      cfg_en_q <= 1'b0;
    end else begin
      if (load_start_i) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= '0;
      end else if (last_issue_o) begin
        rd_en_q <= 1'b0;
      end else if (rd_en_q) begin
        rd_addr_q <= rd_addr_q + AW'(1);
      end
      pend_q   <= rd_en_q;
      cfg_en_q <= pend_q && addr_ok;
      if (pend_q && addr_ok) begin
        cfg_addr_q <= mem_rd_data_i[ADDR_MSB:ADDR_LSB];
        cfg_data_q <= mem_rd_data_i[DATA_MSB:DATA_LSB];
      end
    end
  end

`ifdef CGRA_CFG_ADDR_CHECK_EN
  logic err_q;

  assign addr_ok = (mem_rd_data_i[HI_MSB:HI_LSB] == '0);

  // Sticky until the next accepted start; flushed words never flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clr_err_i) begin
      err_q <= 1'b0;
    end else if (pend_q && !addr_ok && !flush_i) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_hi;

  assign addr_ok   = 1'b1;
  assign err_o     = 1'b0;
  assign unused_hi = ^{mem_rd_data_i[HI_MSB:HI_LSB], clr_err_i};
`endif

  assign mem_rd_en_o   = rd_en_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign cfg_en_o      = cfg_en_q;
  assign cfg_addr_o    = cfg_addr_q;
  assign cfg_data_o    = cfg_data_q;

endmodule

// File: rtl/cgra_cfg_loader.sv
// Start/busy/done engine: load config stream, settle, run compute enables.
// Address-range checking is enabled with CGRA_CFG_ADDR_CHECK_EN.
module cgra_cfg_loader
  import cgra_ctrl_pkg::*;
(
  input logic              clock,
  input logic              reset_n,
  cgra_cfg_loader_if.slave bus
);

  cgra_state_e      state_q, state_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [RUNW-1:0]  run_cnt_q, run_cnt_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             busy_q;
  logic             done_q;
  logic [NEN-1:0]   io_en_q;
  logic             accept;
  logic             load_start;
  logic             last_issue;

  assign accept = (state_q == ST_IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    run_cnt_d  = run_cnt_q;
    drain_d    = drain_q;
    load_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d     = clamp_len(bus.cfg_len);
          run_cnt_d = bus.run_cycles;
          if (len_d == '0) begin
            state_d = ST_DRAIN;
            drain_d = DCW'(DRAIN_TOTAL - 1);
          end else begin
            state_d    = ST_LOAD;
            load_start = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (last_issue) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_TOTAL - 1);
        end
      end
      // DRAIN covers the two words still in flight plus the settle gap.
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = (run_cnt_q == '0) ? ST_DONE : ST_RUN;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q - RUNW'(1);
        if (run_cnt_q == RUNW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are registered from state_d so they line up with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      run_cnt_q <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      io_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      run_cnt_q <= run_cnt_d;
      drain_q   <= drain_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      io_en_q   <= {NEN{state_d == ST_RUN}};
    end
  end

  cgra_cfg_fetch u_fetch (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .load_start_i  (load_start),
    .flush_i       (bus.abort),
    .clr_err_i     (accept),
    .len_i         (len_q),
    .mem_rd_en_o   (bus.mem_rd_en),
    .mem_rd_addr_o (bus.mem_rd_addr),
    .mem_rd_data_i (bus.mem_rd_data),
    .last_issue_o  (last_issue),
    .cfg_en_o      (bus.io_cfg_en),
    .cfg_addr_o    (bus.io_cfg_addr),
    .cfg_data_o    (bus.io_cfg_data),
    .err_o         (bus.err)
  );

  assign bus.io_en     = io_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Self-checking bench for cgra_cfg_loader: vector table of load/run cases,
// scoreboard of expected config writes, and hand-written corner sequences.
module tb_cgra_cfg_loader;
  import cgra_ctrl_pkg::*;

  localparam int W = CGRA_AW + DW;

  typedef struct {
    int len;
    int run;
    int pulses;
    int en_cnt;
    int en_first;
    int done_at;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  cgra_cfg_loader_if bus();

  cgra_cfg_loader dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Config RAM model: one-cycle read latency.
  logic [CFGW-1:0] ram [CFG_LENGTH];
  logic [CFGW-1:0] rd_data_q = '0;
  always @(posedge clock) if (bus.mem_rd_en) rd_data_q <= ram[bus.mem_rd_addr];
  assign bus.mem_rd_data = rd_data_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_T   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int cfg_seen, en_cnt, en_first, done_cnt, done_at;
  vec_t vec[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: times are reported as offsets from the start edge T.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.io_cfg_en) begin
        cfg_seen++;
        check("cfg_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("cfg_word", {bus.io_cfg_addr, bus.io_cfg_data}, exp_q.pop_front());
          check("cfg_slot", cyc + 1 - t_T, exp_t_q.pop_front());
        end
      end
      if (bus.io_en != '0) begin
        check("io_en_value", bus.io_en, {NEN{1'b1}});
        if (en_cnt == 0) en_first = cyc + 1 - t_T;
        en_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_at = cyc + 1 - t_T;
      end
    end
  end

  task automatic clear_mon();
    cfg_seen = 0; en_cnt = 0; en_first = 0; done_cnt = 0; done_at = 0;
    exp_q.delete(); exp_t_q.delete();
  endtask

  task automatic fill_ram(input bit plan);
    for (int i = 0; i < CFG_LENGTH; i++)
      ram[i] = {2'b00, 18'($urandom), 32'($urandom)};
    if (plan) begin
      ram[0] = {20'h00001, 32'h00000011};
      ram[1] = {20'h00002, 32'h00000022};
      ram[2] = {20'h00003, 32'h00000033};
      ram[3] = {20'h00004, 32'h00000044};
    end
  endtask

  // Pulses start for one cycle; expected words are pushed before the edge.
  task automatic start_op(input int len, input int run, input int npush, input int skip);
    @(negedge clock);
    clear_mon();
    t_T = cyc + 1;
    for (int i = 0; i < npush; i++) begin
      if (i != skip) begin
        exp_q.push_back({ram[i][ADDR_MSB:ADDR_LSB], ram[i][DATA_MSB:DATA_LSB]});
        exp_t_q.push_back(3 + i);
      end
    end
    bus.start      = 1'b1;
    bus.cfg_len    = LENW'(len);
    bus.run_cycles = RUNW'(run);
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_at_t1", bus.busy, 1);
    check("rd_en_at_t1", bus.mem_rd_en, len > 0);
    if (len > 0) check("rd_addr_at_t1", bus.mem_rd_addr, 0);
    check("err_cleared_at_start", bus.err, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clock);
    check("done_within_budget", done_cnt != 0, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic run_case(input vec_t v);
    start_op(v.len, v.run, v.pulses, -1);
    wait_done(200);
    check("cfg_pulses", cfg_seen, v.pulses);
    check("cfg_queue_empty", exp_q.size(), 0);
    check("en_cycles", en_cnt, v.en_cnt);
    check("en_first", en_first, v.en_first);
    check("done_at", done_at, v.done_at);
    check("done_once", done_cnt, 1);
    check("idle_after", bus.busy, 0);
    check("state_idle_after", bus.dbg_state, ST_IDLE);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
    check({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
    check({tag, "_io_cfg_en"}, bus.io_cfg_en, 0);
    check({tag, "_io_cfg_addr"}, bus.io_cfg_addr, 0);
    check({tag, "_io_cfg_data"}, bus.io_cfg_data, 0);
    check({tag, "_io_en"}, bus.io_en, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int skip;
    int exp_pulses;
    logic exp_err;

    // {len, run, pulses, en_cnt, en_first, done_at}
    vec[0] = '{4,   3, 4,  3, 9,  12};
    vec[1] = '{0,   0, 0,  0, 0,  5};
    vec[2] = '{1,   1, 1,  1, 6,  7};
    vec[3] = '{64,  2, 64, 2, 69, 71};
    vec[4] = '{100, 0, 64, 0, 0,  69};
    vec[5] = '{7,   5, 7,  5, 12, 17};

    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_len = '0; bus.run_cycles = '0;
    clear_mon();
    fill_ram(1'b1);
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      fill_ram(i == 0);
      run_case(vec[i]);
    end

    // Abort in the middle of LOAD: three words land, then everything stops.
    fill_ram(1'b0);
    start_op(10, 5, 3, -1);
    repeat (4) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_io_cfg_en", bus.io_cfg_en, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_mem_rd_en", bus.mem_rd_en, 0);
    check("abort_io_en", bus.io_en, 0);
    check("abort_done", bus.done, 0);
    repeat (20) @(negedge clock);
    check("abort_no_done", done_cnt, 0);
    check("abort_pulses", cfg_seen, 3);
    check("abort_queue_empty", exp_q.size(), 0);
    fill_ram(1'b1);
    run_case(vec[0]);

    // start together with abort in IDLE starts nothing.
    @(negedge clock);
    clear_mon();
    bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_len = 7'd4; bus.run_cycles = 16'd3;
    @(negedge clock);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_rd_en", bus.mem_rd_en, 0);
    repeat (10) @(negedge clock);
    check("start_abort_no_done", done_cnt, 0);
    check("start_abort_no_cfg", cfg_seen, 0);

    // Asynchronous reset while the enables are up.
    fill_ram(1'b0);
    start_op(2, 20, 2, -1);
    repeat (10) @(negedge clock);
    check("io_en_before_reset", bus.io_en, {NEN{1'b1}});
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    check("reset_no_done", done_cnt, 0);
    check("reset_pulses", cfg_seen, 2);
    run_case(vec[2]);

    // Out-of-range address field in word 2, plus a start while busy.
    fill_ram(1'b1);
    ram[2] = {20'h40005, 32'h00000033};
`ifdef CGRA_CFG_ADDR_CHECK_EN
    skip = 2; exp_pulses = 3; exp_err = 1'b1;
`else
    skip = -1; exp_pulses = 4; exp_err = 1'b0;
`endif
    start_op(4, 3, 4, skip);
    repeat (2) @(negedge clock);
    bus.start = 1'b1; bus.cfg_len = 7'd9; bus.run_cycles = 16'd9;
    @(negedge clock);
    bus.start = 1'b0;
    check("err_before_slot", bus.err, 0);
    @(negedge clock);
    check("err_at_slot", bus.err, exp_err);
    wait_done(200);
    check("addrchk_pulses", cfg_seen, exp_pulses);
    check("addrchk_queue_empty", exp_q.size(), 0);
    check("addrchk_done_at", done_at, 12);
    check("addrchk_en_cycles", en_cnt, 3);
    check("addrchk_err_sticky", bus.err, exp_err);
    fill_ram(1'b0);
    run_case(vec[2]);
    check("err_after_restart", bus.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
